// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: a circular FIFO of word
// stores that drains when the memory port is free and forwards data to loads.
module store_buffer #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_st_valid,
    input  logic [WORD_LEN-1:0]         i_st_addr,
    input  logic [WORD_LEN-1:0]         i_st_data,
    output logic                        o_st_ready,
    input  logic                        i_ld_valid,
    input  logic [WORD_LEN-1:0]         i_ld_addr,
    output logic                        o_fwd_hit,
    output logic [WORD_LEN-1:0]         o_fwd_data,
    output logic                        o_ld_stall,
    output logic                        o_mem_writeEn,
    output logic [WORD_LEN-1:0]         o_mem_address,
    output logic [WORD_LEN-1:0]         o_mem_dataIn,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = WORD_LEN - 2;

    logic [DEPTH-1:0]               r_vld;
    logic [DEPTH-1:0][AW-1:0]       r_addr;
    logic [DEPTH-1:0][WORD_LEN-1:0] r_data;
    logic [PW-1:0]                  r_head;
    logic [PW-1:0]                  r_tail;
    logic [CW-1:0]                  r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_enq;
    logic                w_drain;
    logic                w_hit;
    logic [WORD_LEN-1:0] w_fdata;
    logic [PW-1:0]       w_idx;
    logic                w_unused;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // A pop in the same cycle never frees a slot for a store: readiness is from registered state only.
    assign w_enq   = i_st_valid && !w_full;
    assign w_drain = !w_empty && (!i_ld_valid || w_full);

    // Byte offsets are irrelevant for word stores and word loads.
    assign w_unused = ^{i_st_addr[1:0], i_ld_addr[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            // Enqueue and drain never touch the same slot: enq needs !full, drain needs !empty.
            if (w_enq) begin
                r_vld[r_tail]  <= 1'b1;
                r_addr[r_tail] <= i_st_addr[WORD_LEN-1:2];
                r_data[r_tail] <= i_st_data;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        w_hit   = 1'b0;
        w_fdata = '0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (i_ld_valid && r_vld[w_idx] && (r_addr[w_idx] == i_ld_addr[WORD_LEN-1:2])) begin
                w_hit   = 1'b1;
                w_fdata = r_data[w_idx];
            end
        end
    end

    assign o_st_ready    = !w_full;
    assign o_fwd_hit     = w_hit;
    assign o_fwd_data    = w_fdata;
    assign o_ld_stall    = i_ld_valid && w_full && !w_hit;
    assign o_mem_writeEn = w_drain;
    assign o_mem_address = w_drain ? {r_addr[r_head], 2'b00} : '0;
    assign o_mem_dataIn  = w_drain ? r_data[r_head] : '0;
    assign o_empty       = w_empty;
    assign o_count       = r_count;
endmodule

// File: tb/tb_store_buffer.sv
// Directed vector bench for store_buffer: each row drives one cycle of inputs and
// checks the combinational/registered outputs seen before that cycle's rising edge.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        ld_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        empty;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    store_buffer #(.WORD_LEN(32), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_st_valid(st_valid), .i_st_addr(st_addr), .i_st_data(st_data), .o_st_ready(st_ready),
        .i_ld_valid(ld_valid), .i_ld_addr(ld_addr),
        .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data), .o_ld_stall(ld_stall),
        .o_mem_writeEn(mem_we), .o_mem_address(mem_addr), .o_mem_dataIn(mem_din),
        .o_empty(empty), .o_count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, sv;
        logic [31:0] sa, sd;
        logic        lv;
        logic [31:0] la;
        logic        e_rdy, e_hit;
        logic [31:0] e_fd;
        logic        e_stall, e_we;
        logic [31:0] e_ma, e_md;
        logic        e_empty;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic sv, logic [31:0] sa, logic [31:0] sd,
                                logic lv, logic [31:0] la,
                                logic rdy, logic hit, logic [31:0] fd, logic stall,
                                logic we, logic [31:0] ma, logic [31:0] md,
                                logic emp, logic [2:0] cnt);
        vec_t v;
        v.rst = r; v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
        v.e_rdy = rdy; v.e_hit = hit; v.e_fd = fd; v.e_stall = stall;
        v.e_we = we; v.e_ma = ma; v.e_md = md; v.e_empty = emp; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic sv, logic [31:0] sa, logic [31:0] sd, logic lv, logic [31:0] la);
        rst = r; st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
    endtask

    initial begin
        //        rst sv  st_addr       st_data       lv  ld_addr     | rdy hit fwd_data    stall we mem_addr      mem_din       emp cnt
        // single store drains the cycle after it is accepted
        tbl.push_back(mk(0, 1, 32'h0000_0404, 32'hDEAD_BEEF, 0, 32'h0,       1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         1, 3'd0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,       1, 0, 32'h0, 0, 1, 32'h404, 32'hDEAD_BEEF, 0, 3'd1));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,       1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         1, 3'd0));
        // two stores to one word, load with byte offset forwards the younger; both drain in order
        tbl.push_back(mk(0, 1, 32'h408,       32'h1,         0, 32'h0,       1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         1, 3'd0));
        tbl.push_back(mk(0, 1, 32'h408,       32'h2,         1, 32'h800,     1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         0, 3'd1));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         1, 32'h40B,     1, 1, 32'h2, 0, 0, 32'h0,   32'h0,         0, 3'd2));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,       1, 0, 32'h0, 0, 1, 32'h408, 32'h1,         0, 3'd2));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,       1, 0, 32'h0, 0, 1, 32'h408, 32'h2,         0, 3'd1));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,       1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         1, 3'd0));
        // load held active: fill to DEPTH with no drain, then full forces drain and stalls load
        tbl.push_back(mk(0, 1, 32'h100,       32'hA,         1, 32'h800,     1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         1, 3'd0));
        tbl.push_back(mk(0, 1, 32'h104,       32'hB,         1, 32'h800,     1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         0, 3'd1));
        tbl.push_back(mk(0, 1, 32'h108,       32'hC,         1, 32'h800,     1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         0, 3'd2));
        tbl.push_back(mk(0, 1, 32'h10C,       32'hD,         1, 32'h800,     1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         0, 3'd3));
        tbl.push_back(mk(0, 1, 32'h500,       32'h7,         1, 32'h800,     0, 0, 32'h0, 1, 1, 32'h100, 32'hA,         0, 3'd4));
        tbl.push_back(mk(0, 1, 32'h500,       32'h7,         1, 32'h800,     1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         0, 3'd3));
        // full with a hitting load: no stall, drain still proceeds
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         1, 32'h10C,     0, 1, 32'hD, 0, 1, 32'h104, 32'hB,         0, 3'd4));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,       1, 0, 32'h0, 0, 1, 32'h108, 32'hC,         0, 3'd3));
        tbl.push_back(mk(0, 1, 32'h200,       32'h55,        1, 32'h500,     1, 1, 32'h7, 0, 0, 32'h0,   32'h0,         0, 3'd2));
        // reset overrides a coincident store and drain
        tbl.push_back(mk(1, 1, 32'h300,       32'h66,        0, 32'h0,       1, 0, 32'h0, 0, 1, 32'h10C, 32'hD,         0, 3'd3));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,       1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         1, 3'd0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         1, 32'h300,     1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         1, 3'd0));
        // a store enqueued this cycle is not forwarded until the next
        tbl.push_back(mk(0, 1, 32'h600,       32'h9,         1, 32'h600,     1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         1, 3'd0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         1, 32'h600,     1, 1, 32'h9, 0, 0, 32'h0,   32'h0,         0, 3'd1));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,       1, 0, 32'h0, 0, 1, 32'h600, 32'h9,         0, 3'd1));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,       1, 0, 32'h0, 0, 0, 32'h0,   32'h0,         1, 3'd0));

        drive(1, 0, 32'h0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        chk("reset st_ready", 32'(st_ready), 32'h1);
        chk("reset empty",    32'(empty),    32'h1);
        chk("reset count",    32'(count),    32'h0);
        chk("reset we",       32'(mem_we),   32'h0);
        chk("reset fwd_hit",  32'(fwd_hit),  32'h0);
        chk("reset fwd_data", fwd_data,      32'h0);
        chk("reset ld_stall", 32'(ld_stall), 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lv, tbl[i].la);
            #1;
            chk($sformatf("row%0d st_ready", i), 32'(st_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d fwd_hit", i),  32'(fwd_hit),  32'(tbl[i].e_hit));
            chk($sformatf("row%0d fwd_data", i), fwd_data,      tbl[i].e_fd);
            chk($sformatf("row%0d ld_stall", i), 32'(ld_stall), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d mem_we", i),   32'(mem_we),   32'(tbl[i].e_we));
            chk($sformatf("row%0d mem_addr", i), mem_addr,      tbl[i].e_ma);
            chk($sformatf("row%0d mem_din", i),  mem_din,       tbl[i].e_md);
            chk($sformatf("row%0d empty", i),    32'(empty),    32'(tbl[i].e_empty));
            chk($sformatf("row%0d count", i),    32'(count),    32'(tbl[i].e_cnt));
        end

        // store held back by an active load, then drained within a bounded wait once the load goes away
        @(negedge clk);
        drive(0, 1, 32'h0000_0706, 32'h1234_5678, 1, 32'h900);
        repeat (2) begin
            @(negedge clk);
            drive(0, 0, 32'h0, 32'h0, 1, 32'h900);
            #1;
            chk("held drain we", 32'(mem_we), 32'h0);
            chk("held count",    32'(count),  32'h1);
        end
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 4 && !seen; k++) begin
                #1;
                if (mem_we) begin
                    seen = 1'b1;
                    chk("late drain addr", mem_addr, 32'h0000_0704);
                    chk("late drain data", mem_din,  32'h1234_5678);
                end else begin
                    @(negedge clk);
                end
            end
            chk("late drain seen", 32'(seen), 32'h1);
        end
        @(negedge clk);
        #1;
        chk("final empty", 32'(empty), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
